// File: rtl/next_kb_hotkey.sv
// next_kb_hotkey -- decodes NeXT keyboard events into OSD hotkey pulses.
// Sits downstream of the sound-box top in the clk27 domain. While the hotkey
// modifier combination is held, kb_forward_en drops so hotkey keystrokes are
// withheld from the NeXT.
// Build option: define HOTKEY_REPEAT_EN to build the DELAY/REPEAT autorepeat
// machine and its counter. Without it, each make produces exactly one pulse
// and hk_repeat is always 0.
module next_kb_hotkey #(
    parameter logic [7:0] HOTKEY_MOD    = 8'h18,
    parameter logic [6:0] KEY_UP        = 7'h16,
    parameter logic [6:0] KEY_DOWN      = 7'h0F,
    parameter logic [6:0] KEY_LEFT      = 7'h09,
    parameter logic [6:0] KEY_RIGHT     = 7'h10,
    parameter logic [6:0] KEY_ENTER     = 7'h2A,
    parameter logic [6:0] KEY_MENU      = 7'h49,
    parameter int         REPEAT_DELAY  = 13_500_000,
    parameter int         REPEAT_PERIOD = 2_700_000,
    parameter int         CNT_W         = 24
) (
    input  logic        clk27,
    input  logic        hw_reset_n,
    input  logic [15:0] keycode,
    input  logic        keycode_valid,
    output logic [2:0]  hk_code,
    output logic        hk_valid,
    output logic        hk_repeat,
    output logic        kb_forward_en
);

    // Table lookup: {found, index}. The if-chain runs from hk_code 0 upward,
    // so duplicate table entries resolve to the lowest index.
    function automatic logic [3:0] lookup_key(input logic [6:0] key);
        logic [3:0] res;
        if (key == KEY_UP)         res = {1'b1, 3'd0};
        else if (key == KEY_DOWN)  res = {1'b1, 3'd1};
        else if (key == KEY_LEFT)  res = {1'b1, 3'd2};
        else if (key == KEY_RIGHT) res = {1'b1, 3'd3};
        else if (key == KEY_ENTER) res = {1'b1, 3'd4};
        else if (key == KEY_MENU)  res = {1'b1, 3'd5};
        else                       res = {1'b0, 3'd0};
        return res;
    endfunction

    logic       mods_match_s;
    logic [3:0] lookup_s;
    logic       hit_s;
    logic [2:0] hit_code_s;
    logic       pulse_s;
    logic       pulse_rep_s;
    logic [2:0] pulse_code_s;

    assign mods_match_s = (keycode[14:8] == HOTKEY_MOD[6:0]);
    assign lookup_s     = lookup_key(keycode[6:0]);
    assign hit_code_s   = lookup_s[2:0];
    assign hit_s        = keycode_valid & keycode[15] & ~keycode[7]
                          & mods_match_s & lookup_s[3];

    // Forwarding gate: this register is the complement of the "modifiers match"
    // flag, refreshed on every event. The matching event itself still passes.
    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            kb_forward_en <= 1'b1;
        end else if (keycode_valid) begin
            kb_forward_en <= ~mods_match_s;
        end else begin
            kb_forward_en <= kb_forward_en;
        end
    end

`ifdef HOTKEY_REPEAT_EN
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]       state_r, state_s;
    logic [CNT_W-1:0] counter_r, counter_s;
    logic [6:0]       held_key_r, held_key_s;
    logic             expiry_s;
    logic             held_break_s;
    logic             switch_s;

    assign expiry_s     = ((state_r == ST_DELAY)  && (counter_r == DELAY_LAST)) ||
                          ((state_r == ST_REPEAT) && (counter_r == PERIOD_LAST));
    assign held_break_s = keycode_valid & keycode[15] & keycode[7]
                          & (keycode[6:0] == held_key_r);
    assign switch_s     = hit_s & (keycode[6:0] != held_key_r);

    // Autorepeat next-state. Event handling outranks timer expiry. An expiry
    // that coincides with a non-state-changing event still restarts the timer,
    // but its pulse is dropped.
    always_comb begin
        state_s      = state_r;
        counter_s    = counter_r;
        held_key_s   = held_key_r;
        pulse_s      = 1'b0;
        pulse_rep_s  = 1'b0;
        pulse_code_s = hk_code;
        case (state_r)
            ST_IDLE: begin
                counter_s = CNT_ZERO;
                if (hit_s) begin
                    pulse_s      = 1'b1;
                    pulse_code_s = hit_code_s;
                    held_key_s   = keycode[6:0];
                    state_s      = ST_DELAY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (keycode_valid && !mods_match_s) begin
                    state_s   = ST_IDLE;
                    counter_s = CNT_ZERO;
                end else if (held_break_s) begin
                    state_s   = ST_IDLE;
                    counter_s = CNT_ZERO;
                end else if (switch_s) begin
                    pulse_s      = 1'b1;
                    pulse_code_s = hit_code_s;
                    held_key_s   = keycode[6:0];
                    state_s      = ST_DELAY;
                    counter_s    = CNT_ZERO;
                end else if (expiry_s) begin
                    pulse_s     = ~keycode_valid;
                    pulse_rep_s = 1'b1;
                    state_s     = ST_REPEAT;
                    counter_s   = CNT_ZERO;
                end else begin
                    counter_s = counter_r + CNT_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                counter_s = CNT_ZERO;
            end
        endcase
    end

    // Autorepeat state, counter and latched key.
    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            state_r    <= ST_IDLE;
            counter_r  <= CNT_ZERO;
            held_key_r <= 7'h00;
        end else begin
            state_r    <= state_s;
            counter_r  <= counter_s;
            held_key_r <= held_key_s;
        end
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (REPEAT_DELAY == 0) ^ (REPEAT_PERIOD == 0) ^ (CNT_W == 0);

    // Single-shot decode: every hit produces one initial pulse.
    always_comb begin
        pulse_s      = hit_s;
        pulse_code_s = hit_code_s;
        pulse_rep_s  = 1'b0;
    end
`endif

    // Output pulse register. Code and repeat flag update only together with hk_valid.
    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            hk_valid  <= 1'b0;
            hk_code   <= 3'd0;
            hk_repeat <= 1'b0;
        end else if (pulse_s) begin
            hk_valid  <= 1'b1;
            hk_code   <= pulse_code_s;
            hk_repeat <= pulse_rep_s;
        end else begin
            hk_valid  <= 1'b0;
            hk_code   <= hk_code;
            hk_repeat <= hk_repeat;
        end
    end

endmodule

// File: tb/tb_next_kb_hotkey.sv
// Testbench for next_kb_hotkey: directed scenarios plus randomized keyboard
// traffic, checked every cycle against a timestamp-based reference model.
module tb_next_kb_hotkey;

    localparam int D = 20;
    localparam int P = 8;
`ifdef HOTKEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif
    localparam logic [6:0] KEY_TBL [6] = '{7'h16, 7'h0F, 7'h09, 7'h10, 7'h2A, 7'h49};

    logic        clk27 = 1'b0;
    logic        hw_reset_n;
    logic [15:0] keycode;
    logic        keycode_valid;
    logic [2:0]  hk_code;
    logic        hk_valid;
    logic        hk_repeat;
    logic        kb_forward_en;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state. A held key is tracked as an absolute due-cycle
    // for its next repeat pulse, not as a counter.
    logic       exp_valid, exp_rep, exp_fwd;
    logic [2:0] exp_code;
    bit         m_active;
    logic [6:0] m_key;
    longint     m_due;
    longint     cyc = 0;

    always #5 clk27 = ~clk27;

    next_kb_hotkey #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(8)) dut (
        .clk27        (clk27),
        .hw_reset_n   (hw_reset_n),
        .keycode      (keycode),
        .keycode_valid(keycode_valid),
        .hk_code      (hk_code),
        .hk_valid     (hk_valid),
        .hk_repeat    (hk_repeat),
        .kb_forward_en(kb_forward_en)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int table_index(input logic [6:0] key);
        for (int i = 0; i < 6; i++) begin
            if (KEY_TBL[i] == key) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_rep   = 1'b0;
        exp_fwd   = 1'b1;
        exp_code  = 3'd0;
        m_active  = 1'b0;
        m_key     = 7'h00;
        m_due     = 0;
    endtask

    task automatic model_pulse(input logic [2:0] code, input logic rep);
        exp_valid = 1'b1;
        exp_code  = code;
        exp_rep   = rep;
    endtask

    // Predict outputs for cycle cyc+1 given the inputs applied during cycle cyc.
    task automatic model_step(input logic v, input logic [15:0] kc);
        bit match, hit, due;
        int idx;
        exp_valid = 1'b0;
        match = (kc[14:8] == 7'h18);
        idx   = table_index(kc[6:0]);
        hit   = v && kc[15] && !kc[7] && match && (idx >= 0);
        if (v) exp_fwd = !match;
        due = REP_EN && m_active && (m_due == cyc + 1);
        if (!REP_EN) begin
            if (hit) model_pulse(3'(idx), 1'b0);
        end else if (v && m_active && !match) begin
            m_active = 1'b0;
        end else if (v && m_active && kc[15] && kc[7] && kc[6:0] == m_key) begin
            m_active = 1'b0;
        end else if (hit && (!m_active || kc[6:0] != m_key)) begin
            model_pulse(3'(idx), 1'b0);
            m_active = 1'b1;
            m_key    = kc[6:0];
            m_due    = cyc + 1 + D;
        end else if (due) begin
            if (!v) model_pulse(exp_code, 1'b1);
            m_due = cyc + 1 + P;
        end
    endtask

    // One clock: check current outputs, then apply this cycle's inputs.
    task automatic cycle(input logic v, input logic [15:0] kc);
        @(negedge clk27);
        cyc++;
        check_eq("hk_valid", {31'd0, hk_valid}, {31'd0, exp_valid});
        check_eq("hk_code", {29'd0, hk_code}, {29'd0, exp_code});
        check_eq("hk_repeat", {31'd0, hk_repeat}, {31'd0, exp_rep});
        check_eq("kb_forward_en", {31'd0, kb_forward_en}, {31'd0, exp_fwd});
        keycode_valid = v;
        keycode       = v ? kc : 16'h0000;
        model_step(v, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000);
    endtask

    function automatic logic [15:0] rand_kc();
        logic [6:0] mods, key;
        logic       isk, brk;
        mods = ($urandom_range(0, 9) < 7) ? 7'h18 : 7'($urandom_range(0, 127));
        key  = ($urandom_range(0, 9) < 7) ? KEY_TBL[$urandom_range(0, 5)]
                                          : 7'($urandom_range(0, 127));
        isk  = ($urandom_range(0, 3) != 0);
        brk  = ($urandom_range(0, 2) == 0);
        return {isk, mods, brk, key};
    endfunction

    // Stimulus sequence.
    initial begin
        hw_reset_n    = 1'b0;
        keycode       = 16'h0000;
        keycode_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk27);
        hw_reset_n = 1'b1;

        // Idle after reset.
        idle(10);
        check_eq("reset_valid", {31'd0, hk_valid}, 32'd0);
        check_eq("reset_fwd", {31'd0, kb_forward_en}, 32'd1);
        check_eq("reset_code", {29'd0, hk_code}, 32'd0);

        // Modifiers first, then UP make.
        cycle(1'b1, 16'h1816);
        cycle(1'b1, 16'h9816);
        check_eq("mods_fwd_low", {31'd0, kb_forward_en}, 32'd0);
        cycle(1'b0, 16'h0000);
        check_eq("up_pulse", {31'd0, hk_valid}, 32'd1);
        check_eq("up_code", {29'd0, hk_code}, 32'd0);
        check_eq("up_initial", {31'd0, hk_repeat}, 32'd0);

        // Hold, then break UP.
        idle(50);
        cycle(1'b1, 16'h9896);
        idle(30);

        // Hold UP into REPEAT, then release modifiers.
        cycle(1'b1, 16'h9816);
        idle(35);
        cycle(1'b1, 16'h0016);
        cycle(1'b0, 16'h0000);
        check_eq("cancel_fwd", {31'd0, kb_forward_en}, 32'd1);
        idle(30);

        // UP then DOWN switch mid-delay.
        cycle(1'b1, 16'h1816);
        cycle(1'b1, 16'h9816);
        idle(10);
        cycle(1'b1, 16'h980F);
        cycle(1'b0, 16'h0000);
        check_eq("switch_valid", {31'd0, hk_valid}, 32'd1);
        check_eq("switch_code", {29'd0, hk_code}, 32'd1);
        idle(25);
        cycle(1'b1, 16'h988F);

        // DOWN strobe coinciding with first-repeat expiry of UP.
        cycle(1'b1, 16'h9816);
        idle(D - 1);
        cycle(1'b1, 16'h980F);
        cycle(1'b0, 16'h0000);
        check_eq("coincide_code", {29'd0, hk_code}, 32'd1);
        check_eq("coincide_rep", {31'd0, hk_repeat}, 32'd0);
        idle(5);
        cycle(1'b1, 16'h988F);
        cycle(1'b1, 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) cycle(1'b1, rand_kc());
            else                           cycle(1'b0, 16'h0000);
        end

        // ENTER hold with asynchronous reset mid-hold.
        cycle(1'b1, 16'h1800);
        cycle(1'b1, 16'h982A);
        cycle(1'b0, 16'h0000);
        check_eq("enter_code", {29'd0, hk_code}, 32'd4);
        idle(30);
        #2;
        hw_reset_n = 1'b0;
        #1;
        check_eq("async_valid", {31'd0, hk_valid}, 32'd0);
        check_eq("async_code", {29'd0, hk_code}, 32'd0);
        check_eq("async_rep", {31'd0, hk_repeat}, 32'd0);
        check_eq("async_fwd", {31'd0, kb_forward_en}, 32'd1);
        model_reset();
        idle(3);
        hw_reset_n = 1'b1;
        idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
